// File: rtl/uart_frame_rx.sv
// Oversampled asynchronous serial frame receiver: start / DATA_BITS data / optional parity / 1-2 stop.
// Delivers the word with a one-cycle data_valid strobe plus frame and parity status.
module uart_frame_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_en,
  input  logic                 data_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_error,
  output logic                 parity_error,
  output logic                 busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CNT_MID   = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_END   = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
  localparam logic          ODD       = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t state, state_next;

  logic                 sync1, data_s, data_s_prev;
  logic [CW-1:0]        clk_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 ferr, perr;
  logic                 tick, mid, start_edge;

  assign tick       = (clk_cnt == CNT_END);
  assign mid        = (clk_cnt == CNT_MID);
  assign start_edge = rx_en && data_s_prev && !data_s;

  // Line idles high, so the synchroniser and edge flop reset to 1 to avoid a phantom start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1       <= 1'b1;
      data_s      <= 1'b1;
      data_s_prev <= 1'b1;
    end else begin
      sync1       <= data_in;
      data_s      <= sync1;
      data_s_prev <= data_s;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (start_edge) state_next = START;
      START:  if (mid) state_next = data_s ? IDLE : DATA;
      DATA:   if (tick && bit_cnt == LAST_DATA) state_next = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY: if (tick) state_next = STOP;
      STOP:   if (tick && bit_cnt == LAST_STOP) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  // bit_cnt is reused to count stop bits once the data bits are in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_cnt      <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      ferr         <= 1'b0;
      perr         <= 1'b0;
      data_out     <= '0;
      data_valid   <= 1'b0;
      frame_error  <= 1'b0;
      parity_error <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      case (state)
        IDLE: begin
          clk_cnt <= '0;
          bit_cnt <= '0;
          if (start_edge) begin
            ferr <= 1'b0;
            perr <= 1'b0;
          end
        end
        START: begin
          clk_cnt <= mid ? '0 : clk_cnt + 1'b1;
        end
        DATA: begin
          if (tick) begin
            clk_cnt <= '0;
            shreg   <= {data_s, shreg[DATA_BITS-1:1]};
            bit_cnt <= (bit_cnt == LAST_DATA) ? '0 : bit_cnt + 1'b1;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        PARITY: begin
          if (tick) begin
            clk_cnt <= '0;
            perr    <= (^shreg) ^ data_s ^ ODD;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        STOP: begin
          if (tick) begin
            clk_cnt <= '0;
            bit_cnt <= bit_cnt + 1'b1;
            ferr    <= ferr | ~data_s;
            if (bit_cnt == LAST_STOP) begin
              data_out     <= shreg;
              frame_error  <= ferr | ~data_s;
              parity_error <= perr;
              data_valid   <= 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: clk_cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Bench for uart_frame_rx: three instances (8N1, 8E1, 5N2) driven bit-serially,
// checked against a queue of expected words, status and e0-to-valid latency.
module tb_uart_frame_rx;

  localparam int OS = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rx_en_a = 1'b1;
  logic rx_a = 1'b1, rx_b = 1'b1, rx_c = 1'b1;

  logic [7:0] data_out_a, data_out_b;
  logic [4:0] data_out_c;
  logic dv_a, fe_a, pe_a, busy_a;
  logic dv_b, fe_b, pe_b, busy_b;
  logic dv_c, fe_c, pe_c, busy_c;

  int cyc = 0;
  int vec_cnt = 0;
  int err_cnt = 0;

  // Entries are {parity_error, frame_error, data (zero-extended to 9 bits)}.
  logic [10:0] exp_a_q[$], exp_b_q[$], exp_c_q[$];
  int e0_a_q[$], e0_b_q[$], e0_c_q[$];
  int c_seen = 0;
  int c_last = 0;

  uart_frame_rx #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_a (
    .clk(clk), .reset(reset), .rx_en(rx_en_a), .data_in(rx_a),
    .data_out(data_out_a), .data_valid(dv_a), .frame_error(fe_a),
    .parity_error(pe_a), .busy(busy_a));

  uart_frame_rx #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_b (
    .clk(clk), .reset(reset), .rx_en(1'b1), .data_in(rx_b),
    .data_out(data_out_b), .data_valid(dv_b), .frame_error(fe_b),
    .parity_error(pe_b), .busy(busy_b));

  uart_frame_rx #(.DATA_BITS(5), .OVERSAMPLE(OS), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_c (
    .clk(clk), .reset(reset), .rx_en(1'b1), .data_in(rx_c),
    .data_out(data_out_c), .data_valid(dv_c), .frame_error(fe_c),
    .parity_error(pe_c), .busy(busy_c));

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // driver
  task automatic set_line(input int line, input logic v);
    case (line)
      0: rx_a = v;
      1: rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  task automatic send_bits(input int line, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      set_line(line, bits[i]);
      repeat (OS) @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_bits(input int n);
    repeat (n * OS) @(posedge clk);
    #1;
  endtask

  // Line goes low now, so the start bit is captured at the next edge (e0).
  task automatic send_a(input logic [7:0] d, input logic stop, input logic expect_word);
    if (expect_word) begin
      exp_a_q.push_back({1'b0, ~stop, 1'b0, d});
      e0_a_q.push_back(cyc + 1);
    end
    send_bits(0, {6'b111111, stop, d, 1'b0}, 10);
  endtask

  task automatic send_b(input logic [7:0] d, input logic par, input logic exp_perr);
    exp_b_q.push_back({exp_perr, 1'b0, 1'b0, d});
    e0_b_q.push_back(cyc + 1);
    send_bits(1, {5'b11111, 1'b1, par, d, 1'b0}, 11);
  endtask

  task automatic send_c(input logic [4:0] d);
    exp_c_q.push_back({2'b00, 4'b0000, d});
    e0_c_q.push_back(cyc + 1);
    send_bits(2, {8'hFF, 2'b11, d, 1'b0}, 8);
  endtask

  // scoreboard
  always @(negedge clk) begin
    logic [10:0] e;
    int t;
    if (dv_a) begin
      if (exp_a_q.size() == 0) check("a_unexpected_valid", 1, 0);
      else begin
        e = exp_a_q.pop_front();
        t = e0_a_q.pop_front();
        check("a_word", {pe_a, fe_a, 1'b0, data_out_a}, e);
        check("a_latency", cyc - t, 154);
      end
    end
    if (dv_b) begin
      if (exp_b_q.size() == 0) check("b_unexpected_valid", 1, 0);
      else begin
        e = exp_b_q.pop_front();
        t = e0_b_q.pop_front();
        check("b_word", {pe_b, fe_b, 1'b0, data_out_b}, e);
        check("b_latency", cyc - t, 170);
      end
    end
    if (dv_c) begin
      if (exp_c_q.size() == 0) check("c_unexpected_valid", 1, 0);
      else begin
        e = exp_c_q.pop_front();
        t = e0_c_q.pop_front();
        check("c_word", {pe_c, fe_c, 4'b0000, data_out_c}, e);
        check("c_latency", cyc - t, 122);
        if (c_seen == 1) check("c_back_to_back_gap", cyc - c_last, 128);
        c_seen++;
        c_last = cyc;
      end
    end
  end

  initial begin
    int waited;
    repeat (3) @(posedge clk);
    #1;
    check("reset_a", {data_out_a, dv_a, fe_a, pe_a, busy_a}, 0);
    check("reset_b", {data_out_b, dv_b, fe_b, pe_b, busy_b}, 0);
    check("reset_c", {data_out_c, dv_c, fe_c, pe_c, busy_c}, 0);
    reset = 1'b0;
    idle_bits(2);

    // 8N1 good frame, then a frame with a low stop bit held low afterwards
    send_a(8'hA5, 1'b1, 1'b1);
    idle_bits(2);
    send_a(8'h3C, 1'b0, 1'b1);
    rx_a = 1'b0;
    idle_bits(3);
    rx_a = 1'b1;
    idle_bits(2);

    // 4-cycle glitch: false start, busy timing, outputs hold
    rx_a = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("glitch_busy_e1", busy_a, 0);
    @(posedge clk);
    #1;
    check("glitch_busy_e2", busy_a, 1);
    @(posedge clk);
    #1;
    rx_a = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("glitch_busy_e9", busy_a, 1);
    @(posedge clk);
    #1;
    check("glitch_busy_e10", busy_a, 0);
    idle_bits(2);
    check("glitch_hold", {fe_a, pe_a, data_out_a}, {1'b1, 1'b0, 8'h3C});

    // start blocked while rx_en is low
    rx_en_a = 1'b0;
    send_a(8'h55, 1'b1, 1'b0);
    rx_en_a = 1'b1;
    idle_bits(2);

    // even parity: 0x07 has three ones, so parity bit 1 is correct
    send_b(8'h07, 1'b1, 1'b0);
    idle_bits(1);
    send_b(8'h07, 1'b0, 1'b1);
    idle_bits(2);

    // 5N2 back-to-back with no idle time
    send_c(5'h15);
    send_c(5'h15);
    idle_bits(2);

    // reset during data bit 3 (0x33 -> bits 1,1,0,0,...)
    send_bits(0, 16'b0110, 4);
    rx_a = 1'b0;
    repeat (OS / 2) @(posedge clk);
    #1;
    check("abort_busy_before_reset", busy_a, 1);
    reset = 1'b1;
    #1;
    check("abort_reset_outputs", {data_out_a, dv_a, fe_a, pe_a, busy_a}, 0);
    rx_a = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    idle_bits(2);
    send_a(8'h5A, 1'b1, 1'b1);
    idle_bits(2);

    waited = 0;
    while ((exp_a_q.size() + exp_b_q.size() + exp_c_q.size()) != 0 && waited < 500) begin
      @(posedge clk);
      waited++;
    end
    #1;
    check("drain_a", exp_a_q.size(), 0);
    check("drain_b", exp_b_q.size(), 0);
    check("drain_c", exp_c_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
